// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM test-path command sequencer: command
// encodings, progress codes, sequence slot indices and the slot lookup.
package sdram_pkg;

    localparam int CMD_W = 4;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    // Progress codes reported on cmd_sent
    localparam logic [1:0] SENT_NONE = 2'b00;
    localparam logic [1:0] SENT_WR   = 2'b01;
    localparam logic [1:0] SENT_RD   = 2'b10;
    localparam logic [1:0] SENT_DONE = 2'b11;

    // Slot indices with side effects on the progress code
    localparam logic [2:0] SLOT_WRITE = 3'd1;
    localparam logic [2:0] SLOT_READ  = 3'd4;
    localparam logic [2:0] SLOT_LAST  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Fixed write/read-back sequence; out-of-range slots map to NOP.
    function automatic logic [3:0] slot_cmd(input logic [2:0] slot);
        logic [3:0] c;
        case (slot)
            3'd0:    c = CMD_ACTIVE;
            3'd1:    c = CMD_WRITE;
            3'd2:    c = CMD_PRECHARGE;
            3'd3:    c = CMD_ACTIVE;
            3'd4:    c = CMD_READ;
            3'd5:    c = CMD_PRECHARGE;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sdram_command.sv
// SDRAM test-path command sequencer. After init completes it claims the
// command bus and steps through a six-command write/read-back sequence,
// advancing one command per cmd_done handshake. All outputs are registered.
module sdram_command
    import sdram_pkg::*;
#(
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_done,
    input  logic             init_comp,
    output logic [CMD_W-1:0] cmd,
    output logic             switch,
    output logic [1:0]       cmd_sent
);

    state_e           state_q;
    logic [2:0]       slot_q;
    logic [2:0]       slot_d;
    logic [CMD_W-1:0] cmd_q;
    logic             switch_q;
    logic [1:0]       sent_q;

    // Candidate slot for the next command once the current one has timed out
    assign slot_d = slot_q + 3'd1;

    // Sequencer FSM: commands are driven for exactly the ISSUE cycle, so the
    // next command is loaded on the same edge that enters ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= 3'd0;
            cmd_q    <= CMD_W'(CMD_NOP);
            switch_q <= 1'b0;
            sent_q   <= SENT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_q <= CMD_W'(CMD_NOP);
                    if (init_comp) begin
                        state_q  <= ST_ISSUE;
                        slot_q   <= 3'd0;
                        cmd_q    <= CMD_W'(slot_cmd(3'd0));
                        switch_q <= 1'b1;
                    end
                end
                // cmd_done is deliberately ignored here so a held level
                // cannot skip a slot.
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    cmd_q   <= CMD_W'(CMD_NOP);
                end
                ST_WAIT: begin
                    cmd_q <= CMD_W'(CMD_NOP);
                    if (cmd_done) begin
                        if (slot_q == SLOT_LAST) begin
                            state_q <= ST_DONE;
                            sent_q  <= SENT_DONE;
                        end else begin
                            state_q <= ST_ISSUE;
                            slot_q  <= slot_d;
                            cmd_q   <= CMD_W'(slot_cmd(slot_d));
                            if (slot_d == SLOT_WRITE) sent_q <= SENT_WR;
                            if (slot_d == SLOT_READ)  sent_q <= SENT_RD;
                        end
                    end
                end
                // Terminal: only reset leaves DONE.
                default: begin
                    state_q <= ST_DONE;
                    cmd_q   <= CMD_W'(CMD_NOP);
                end
            endcase
        end
    end

    assign cmd      = cmd_q;
    assign switch   = switch_q;
    assign cmd_sent = sent_q;

endmodule

// File: tb/tb_sdram_command.sv
// Scoreboard bench for sdram_command: the stimulus process advances a
// count-based reference model and queues the expected outputs after every
// clock edge; a monitor pops and compares them on each falling edge.
module tb_sdram_command;

    logic       clk;
    logic       rst;
    logic       cmd_done;
    logic       init_comp;
    logic [3:0] cmd;
    logic       switch;
    logic [1:0] cmd_sent;

    sdram_command #(.CMD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_done  (cmd_done),
        .init_comp (init_comp),
        .cmd       (cmd),
        .switch    (switch),
        .cmd_sent  (cmd_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cmd;
        logic       sw;
        logic [1:0] sent;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    // Reference model: how many sequence commands have been issued, whether
    // the newest one is on the bus this cycle, and whether the final timeout
    // has been acknowledged.
    logic [3:0] seq [6];
    bit m_sw, m_vis, m_done;
    int m_n;

    task automatic model_reset();
        m_sw = 0; m_vis = 0; m_done = 0; m_n = 0;
    endtask

    task automatic model_step(input bit r, input bit i, input bit d);
        if (r) begin
            model_reset();
        end else if (!m_sw) begin
            if (i) begin m_sw = 1; m_n = 1; m_vis = 1; end
        end else if (m_vis) begin
            m_vis = 0;
        end else if (!m_done && d) begin
            if (m_n < 6) begin m_n++; m_vis = 1; end
            else m_done = 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.cmd  = m_vis ? seq[m_n-1] : 4'b0111;
        e.sw   = m_sw;
        e.sent = m_done ? 2'b11 : (m_n >= 5) ? 2'b10 : (m_n >= 2) ? 2'b01 : 2'b00;
        return e;
    endfunction

    // One clock cycle: inputs change just after the falling edge, the
    // expected post-edge outputs are queued at the rising edge.
    task automatic cyc(input bit r, input bit i, input bit d);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; init_comp = i; cmd_done = d;
        model_step(r, i, d);
        e = model_out();
        @(posedge clk);
        cyc_no++;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output word against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (cmd === e.cmd && switch === e.sw && cmd_sent === e.sent) begin
                n_pass++;
            end else begin
                $display("FAIL cycle%0d outputs: cmd=%b switch=%b cmd_sent=%b, expected cmd=%b switch=%b cmd_sent=%b",
                         cyc_no, cmd, switch, cmd_sent, e.cmd, e.sw, e.sent);
            end
        end
    end

    task automatic run_pulses(input int npulse);
        for (int p = 0; p < npulse; p++) begin
            int gap;
            gap = $urandom_range(3, 7);
            for (int g = 0; g < gap; g++) cyc(0, 1'($urandom_range(0, 1)), 0);
            cyc(0, 1'($urandom_range(0, 1)), 1);
        end
    endtask

    initial begin
        seq[0] = 4'b0011; seq[1] = 4'b0100; seq[2] = 4'b0010;
        seq[3] = 4'b0011; seq[4] = 4'b0101; seq[5] = 4'b0010;
        model_reset();
        rst = 1'b1; init_comp = 1'b0; cmd_done = 1'b0;

        // Reset held for five cycles
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        // Idle, with stray cmd_done that must not be queued
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        // Claim the bus and run the full sequence with spaced pulses
        cyc(0, 1, 0);
        run_pulses(7);
        // Sync reset, then restart with a pulse in the ISSUE cycle and a held level
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1);
        cyc(0, 0, 0);

        // Advance into the wait after the first PRECHARGE, then reset asynchronously
        for (int k = 0; k < 40 && !(m_n == 3 && !m_vis); k++)
            cyc(0, 0, 1'($urandom_range(0, 1)));
        if (!(m_n == 3 && !m_vis)) begin
            n_checks++;
            $display("FAIL reach_wait2: slots issued=%0d, required 3", m_n);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cmd === 4'b0111 && switch === 1'b0 && cmd_sent === 2'b00) n_pass++;
        else $display("FAIL async_reset: cmd=%b switch=%b cmd_sent=%b, expected 0111/0/00",
                      cmd, switch, cmd_sent);
        model_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // Restart from slot 0, finish with random cmd_done density
        cyc(0, 1, 0);
        for (int k = 0; k < 200 && !m_done; k++)
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        if (!m_done) begin
            n_checks++;
            $display("FAIL reach_done: slots issued=%0d, sequence not complete", m_n);
        end
        // DONE is sticky against init_comp toggling and cmd_done pulses
        for (int k = 0; k < 50; k++)
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
